// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
//
// Shared definitions for the pipelined shift unit.
//   - Operation encodings carried on in_op and through every pipeline stage.
//   - A helper that derives the shift-amount width (and so the number of
//     pipeline stages) from the operand width.
// ---------------------------------------------------------------------------
package shift_pkg;

    // Operation encodings
    localparam logic [1:0] OP_SLL = 2'b00;  // logical left, zero fill at LSB
    localparam logic [1:0] OP_SRL = 2'b01;  // logical right, zero fill at MSB
    localparam logic [1:0] OP_SRA = 2'b10;  // arithmetic right, sign fill at MSB
    localparam logic [1:0] OP_ROR = 2'b11;  // rotate right

    // Default build: 32-bit operand, 5 log-stages
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SH_W  = $clog2(DEFAULT_WIDTH);

    // Shift-amount width for a given operand width. Also the pipeline depth,
    // since there is one registered stage per amount bit.
    function automatic int sh_w_of(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// ---------------------------------------------------------------------------
// shift_stage
//
// One log-stage of the shifter: purely combinational. When enabled it shifts
// or rotates the operand right/left by the fixed distance DIST according to
// the operation; when disabled the operand passes through unchanged.
//
// Parameters:
//   WIDTH  operand width
//   DIST   fixed shift distance of this stage (a power of two, < WIDTH)
//
// Ports:
//   i_data    operand coming into this stage
//   i_enable  this stage's amount bit; 0 = pass through
//   i_op      operation encoding (see shift_pkg)
//   i_sign    sign bit of the ORIGINAL operand, used as SRA fill
//   o_data    stage result
// ---------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_enable,
    input  logic [1:0]       i_op,
    input  logic             i_sign,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_ror;

    assign w_sll = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
    assign w_srl = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
    // The fill comes from the captured sign, not from i_data[WIDTH-1]: an
    // earlier SRA stage has already replicated it, but keeping the original
    // sign alongside the data makes every stage independent of that.
    assign w_sra = {{DIST{i_sign}}, i_data[WIDTH-1:DIST]};
    assign w_ror = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};

    always_comb begin
        o_data = i_data;
        if (i_enable) begin
            case (i_op)
                OP_SLL:  o_data = w_sll;
                OP_SRL:  o_data = w_srl;
                OP_SRA:  o_data = w_sra;
                OP_ROR:  o_data = w_ror;
                default: o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shift_unit.sv
// ---------------------------------------------------------------------------
// pipelined_shift_unit
//
// Pipelined barrel shifter: SLL, SRL, SRA and ROR on a WIDTH-bit operand.
// Stage k shifts by 2^k when amount bit k is set and registers its result,
// so latency is SH_W cycles with no stall. A tag rides alongside each
// operation and comes out with its result.
//
// Handshake (both sides are plain valid/ready):
//   A transfer happens on a rising edge where valid && ready are both high.
//   valid, once raised, is held with its payload stable until the transfer.
//   Here the pipeline moves as one unit: advance = !out_valid || out_ready.
//   in_ready is advance itself (combinational), so an operation is accepted
//   exactly when the pipeline moves; a cycle with in_valid low while moving
//   injects a bubble. When out_valid && !out_ready every stage holds.
//
// Parameters:
//   WIDTH  operand width, power of two from 8 to 64
//   TAG_W  sideband tag width
//   SH_W   derived amount width / number of stages (not overridable)
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_data             operand
//   in_amount           shift distance 0..WIDTH-1
//   in_op               00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_tag              sideband carried with the operation
//   out_valid/out_ready output handshake
//   out_data, out_tag   result and its tag
//   out_zero            out_data == 0
//   busy                any stage holds a valid operation
// ---------------------------------------------------------------------------
module pipelined_shift_unit
    import shift_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int TAG_W = 5,
    localparam int SH_W  = sh_w_of(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_amount,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,

    output logic             busy
);

    // -----------------------------------------------------------------------
    // Stage registers. Valid, data and tag exist for every stage. Amount, op
    // and sign only steer the following stage, so the final stage (which has
    // no successor) does not keep them.
    // -----------------------------------------------------------------------
    logic [SH_W-1:0]  r_valid;
    logic [WIDTH-1:0] r_data   [SH_W];
    logic [TAG_W-1:0] r_tag    [SH_W];
    logic [SH_W-1:0]  r_amount [SH_W-1];
    logic [1:0]       r_op     [SH_W-1];
    logic [SH_W-2:0]  r_sign;

    // Inputs seen by each stage: the unit's inputs for stage 0, the previous
    // stage's registers otherwise.
    logic [WIDTH-1:0] w_stage_in  [SH_W];
    logic [WIDTH-1:0] w_stage_out [SH_W];
    logic [SH_W-1:0]  w_amt_in    [SH_W];
    logic [1:0]       w_op_in     [SH_W];
    logic [TAG_W-1:0] w_tag_in    [SH_W];
    logic [SH_W-1:0]  w_sign_in;

    logic             w_advance;

    assign w_advance = !r_valid[SH_W-1] || out_ready;

    // -----------------------------------------------------------------------
    // Combinational log-stages
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < SH_W; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_stage_in[k] = in_data;
            assign w_amt_in[k]   = in_amount;
            assign w_op_in[k]    = in_op;
            assign w_tag_in[k]   = in_tag;
            // Sign is captured from the operand as presented, before any
            // stage has touched it.
            assign w_sign_in[k]  = in_data[WIDTH-1];
        end else begin : g_next
            assign w_stage_in[k] = r_data[k-1];
            assign w_amt_in[k]   = r_amount[k-1];
            assign w_op_in[k]    = r_op[k-1];
            assign w_tag_in[k]   = r_tag[k-1];
            assign w_sign_in[k]  = r_sign[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .i_data   (w_stage_in[k]),
            .i_enable (w_amt_in[k][k]),
            .i_op     (w_op_in[k]),
            .i_sign   (w_sign_in[k]),
            .o_data   (w_stage_out[k])
        );
    end

    // -----------------------------------------------------------------------
    // Pipeline registers. Everything moves together on advance; nothing
    // moves during a stall. Reset discards in-flight work and zeroes the
    // payload so the output side reads as a clean, empty result.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_sign  <= '0;
            for (int k = 0; k < SH_W; k++) begin
                r_data[k] <= '0;
                r_tag[k]  <= '0;
            end
            for (int k = 0; k < SH_W - 1; k++) begin
                r_amount[k] <= '0;
                r_op[k]     <= '0;
            end
        end else if (w_advance) begin
            // in_valid low while advancing shifts a bubble into stage 0
            r_valid <= {r_valid[SH_W-2:0], in_valid};
            for (int k = 0; k < SH_W; k++) begin
                r_data[k] <= w_stage_out[k];
                r_tag[k]  <= w_tag_in[k];
            end
            for (int k = 0; k < SH_W - 1; k++) begin
                r_amount[k] <= w_amt_in[k];
                r_op[k]     <= w_op_in[k];
                r_sign[k]   <= w_sign_in[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready  = w_advance;
    assign out_valid = r_valid[SH_W-1];
    assign out_data  = r_data[SH_W-1];
    assign out_tag   = r_tag[SH_W-1];
    assign out_zero  = (r_data[SH_W-1] == '0);
    assign busy      = |r_valid;

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_shift_unit
//
// Bench for pipelined_shift_unit: a 32-bit instance exercised with a vector
// table, hand-written stall/reset sequences and random traffic against a
// reference model, plus an 8-bit instance for the narrow build.
// ---------------------------------------------------------------------------
module tb_pipelined_shift_unit;
    import shift_pkg::*;

    localparam int W   = 32;
    localparam int SW  = 5;
    localparam int TW  = 5;
    localparam int W8  = 8;
    localparam int SW8 = 3;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // 32-bit DUT signals
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data   = '0;
    logic [SW-1:0] in_amount = '0;
    logic [1:0]    in_op     = '0;
    logic [TW-1:0] in_tag    = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          out_zero;
    logic          busy;

    // 8-bit DUT signals
    logic           b_in_valid  = 1'b0;
    logic           b_in_ready;
    logic [W8-1:0]  b_in_data   = '0;
    logic [SW8-1:0] b_in_amount = '0;
    logic [1:0]     b_in_op     = '0;
    logic [TW-1:0]  b_in_tag    = '0;
    logic           b_out_valid;
    logic [W8-1:0]  b_out_data;
    logic [TW-1:0]  b_out_tag;
    logic           b_out_zero;
    logic           b_busy;

    pipelined_shift_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amount (in_amount),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero),
        .busy      (busy)
    );

    pipelined_shift_unit #(.WIDTH(W8), .TAG_W(TW)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_amount (b_in_amount),
        .in_op     (b_in_op),
        .in_tag    (b_in_tag),
        .out_valid (b_out_valid),
        .out_ready (1'b1),
        .out_data  (b_out_data),
        .out_tag   (b_out_tag),
        .out_zero  (b_out_zero),
        .busy      (b_busy)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    logic [TW+W-1:0] exp_q[$];
    logic [W-1:0]    cur_exp;
    int              checks     = 0;
    int              errors     = 0;
    int              cyc        = 0;
    int              acc_cyc    = 0;
    int              deliv_cyc  = 0;
    int              deliv_cnt  = 0;
    bit              rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference model: shift rules applied with plain arithmetic on a
    // w-bit value held in 64 bits.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int amt,
                                              input logic [1:0] op, input int w);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        d    = d & mask;
        case (op)
            OP_SLL:  r = (d << amt) & mask;
            OP_SRL:  r = d >> amt;
            OP_SRA: begin
                r = d >> amt;
                if (d[w-1]) r = r | (mask & ~(mask >> amt));
            end
            default: r = ((d >> amt) | (d << (w - amt))) & mask;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Driver / monitor: one cycle. Inputs are set just after a falling edge;
    // handshakes are sampled 1 time unit later, then the rising edge fires.
    // -----------------------------------------------------------------------
    task automatic tick(output bit acc);
        logic [TW+W-1:0] e;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        #1;
        acc = 1'b0;
        if (!reset) begin
            if (out_valid && out_ready) begin
                deliv_cnt++;
                deliv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[W-1:0]);
                    check("out_tag", out_tag, e[TW+W-1:W]);
                    check("out_zero", out_zero, (e[W-1:0] == '0));
                end
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back({in_tag, cur_exp});
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic send(input logic [1:0] op, input logic [SW-1:0] amt,
                        input logic [W-1:0] data, input logic [TW-1:0] tag,
                        input logic [W-1:0] exp);
        bit acc;
        int n;
        in_valid  = 1'b1;
        in_op     = op;
        in_amount = amt;
        in_data   = data;
        in_tag    = tag;
        cur_exp   = exp;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            tick(acc);
            n++;
        end
        if (!acc) fail_now("send_timeout");
        in_valid = 1'b0;
    endtask

    task automatic send_random();
        logic [63:0] r;
        logic [1:0]  op;
        int          amt;
        logic [W-1:0] d;
        op  = 2'($urandom_range(0, 3));
        amt = $urandom_range(0, W - 1);
        d   = $urandom;
        r   = ref_shift({32'd0, d}, amt, op, W);
        send(op, SW'(amt), d, TW'($urandom_range(0, 31)), r[W-1:0]);
    endtask

    task automatic drain();
        bit acc;
        int n;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(acc);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        #1;
        check("drain_busy", busy, 0);
    endtask

    // 8-bit instance: one isolated operation, latency and result checked.
    task automatic run8(input logic [1:0] op, input int amt, input logic [W8-1:0] data,
                        input logic [TW-1:0] tag, input logic [W8-1:0] exp);
        int lat;
        bit seen;
        b_in_valid  = 1'b1;
        b_in_op     = op;
        b_in_amount = SW8'(amt);
        b_in_data   = data;
        b_in_tag    = tag;
        #1;
        check("b_in_ready", b_in_ready, 1);
        @(posedge clock);
        @(negedge clock);
        b_in_valid = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            #1;
            if (b_out_valid) seen = 1'b1;
            else begin
                @(posedge clock);
                @(negedge clock);
                lat++;
            end
        end
        if (!seen) fail_now("b_timeout");
        else begin
            check("b_latency", lat, SW8);
            check("b_out_data", b_out_data, exp);
            check("b_out_tag", b_out_tag, tag);
            check("b_out_zero", b_out_zero, (exp == '0));
        end
        @(posedge clock);
        @(negedge clock);
        #1;
        check("b_after_valid", b_out_valid, 0);
    endtask

    // -----------------------------------------------------------------------
    // Vector table
    // -----------------------------------------------------------------------
    typedef struct {
        logic [1:0]   op;
        int           amt;
        logic [W-1:0] data;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        bit          acc;
        int          d0;
        int          first_acc;
        logic [TW+W-1:0] hold;
        logic [63:0] r;

        vecs[0]  = '{OP_SRA, 31, 32'h8000_0000, 32'hFFFF_FFFF};
        vecs[1]  = '{OP_SRL, 31, 32'h8000_0000, 32'h0000_0001};
        vecs[2]  = '{OP_SLL, 31, 32'h0000_0001, 32'h8000_0000};
        vecs[3]  = '{OP_ROR, 1,  32'h0000_0001, 32'h8000_0000};
        vecs[4]  = '{OP_SRA, 4,  32'h7FFF_FFF0, 32'h07FF_FFFF};
        vecs[5]  = '{OP_SRA, 0,  32'hF0F0_F0F0, 32'hF0F0_F0F0};
        vecs[6]  = '{OP_SRA, 1,  32'hF0F0_F0F0, 32'hF878_7878};
        vecs[7]  = '{OP_SRA, 2,  32'hF0F0_F0F0, 32'hFC3C_3C3C};
        vecs[8]  = '{OP_SRA, 3,  32'hF0F0_F0F0, 32'hFE1E_1E1E};
        vecs[9]  = '{OP_SRA, 4,  32'hF0F0_F0F0, 32'hFF0F_0F0F};
        vecs[10] = '{OP_SRA, 5,  32'hF0F0_F0F0, 32'hFF87_8787};
        vecs[11] = '{OP_SRA, 6,  32'hF0F0_F0F0, 32'hFFC3_C3C3};
        vecs[12] = '{OP_SRA, 7,  32'hF0F0_F0F0, 32'hFFE1_E1E1};
        vecs[13] = '{OP_ROR, 8,  32'h1234_5678, 32'h7812_3456};
        vecs[14] = '{OP_SLL, 4,  32'hFFFF_FFFF, 32'hFFFF_FFF0};
        vecs[15] = '{OP_SRL, 1,  32'h0000_0001, 32'h0000_0000};

        // ---- reset state ----
        reset = 1'b1;
        repeat (3) tick(acc);
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_zero", out_zero, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clock);

        // ---- single op latency: SRA 0x80000000 by 31 ----
        send(OP_SRA, 5'd31, 32'h8000_0000, 5'd3, 32'hFFFF_FFFF);
        drain();
        check("latency", deliv_cyc - acc_cyc, SW);

        // ---- table streamed back to back ----
        d0 = deliv_cnt;
        first_acc = 0;
        for (int i = 0; i < 16; i++) begin
            send(vecs[i].op, SW'(vecs[i].amt), vecs[i].data, TW'(i), vecs[i].exp);
            if (i == 0) first_acc = acc_cyc;
        end
        drain();
        check("stream_count", deliv_cnt - d0, 16);
        check("stream_span", deliv_cyc - first_acc, 15 + SW);

        // ---- backpressure: fill with out_ready low, then stall 4 cycles ----
        d0 = deliv_cnt;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r = ref_shift(64'(32'hA5C3_0F81 + i), i * 3, 2'(i), W);
            send(2'(i), SW'(i * 3), 32'hA5C3_0F81 + i, TW'(20 + i), r[W-1:0]);
        end
        r = ref_shift(64'h0000_0000_DEAD_BEEF, 13, OP_ROR, W);
        in_valid  = 1'b1;
        in_op     = OP_ROR;
        in_amount = 5'd13;
        in_data   = 32'hDEAD_BEEF;
        in_tag    = 5'd30;
        cur_exp   = r[W-1:0];
        hold = exp_q[0];
        for (int s = 0; s < 4; s++) begin
            #1;
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, hold[W-1:0]);
            check("stall_out_tag", out_tag, hold[TW+W-1:W]);
            tick(acc);
        end
        out_ready = 1'b1;
        tick(acc);
        check("release_accept", acc, 1);
        in_valid = 1'b0;
        drain();
        check("stall_count", deliv_cnt - d0, 6);

        // ---- reset with 3 ops in flight ----
        for (int i = 0; i < 3; i++) send(OP_SLL, SW'(i + 1), 32'h0000_00FF, TW'(i), 32'h1);
        reset = 1'b1;
        exp_q.delete();
        tick(acc);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_zero", out_zero, 1);
        check("midrst_out_data", out_data, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clock);
        d0 = deliv_cnt;
        send(OP_SRL, 5'd4, 32'h1234_5678, 5'd17, 32'h0123_4567);
        repeat (3) tick(acc);
        drain();
        check("postrst_count", deliv_cnt - d0, 1);

        // ---- random traffic with random backpressure ----
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) send_random();
            else tick(acc);
        end
        drain();

        // ---- 8-bit build ----
        run8(OP_ROR, 7, 8'h81, 5'd1, 8'h03);
        run8(OP_SLL, 0, 8'hFF, 5'd2, 8'hFF);
        run8(OP_SRA, 7, 8'h80, 5'd3, 8'hFF);
        run8(OP_SRL, 7, 8'h80, 5'd4, 8'h01);
        run8(OP_SLL, 7, 8'h03, 5'd5, 8'h80);
        for (int i = 0; i < 20; i++) begin
            logic [1:0]    op8;
            int            amt8;
            logic [W8-1:0] d8;
            op8  = 2'($urandom_range(0, 3));
            amt8 = $urandom_range(0, W8 - 1);
            d8   = 8'($urandom);
            r    = ref_shift({56'd0, d8}, amt8, op8, W8);
            run8(op8, amt8, d8, TW'(i), r[W8-1:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_shift_unit.md
Name: pipelined_shift_unit

Overview:
Parametrised, pipelined successor to the datapath's fixed 32-bit arithmetic right shifter. Performs logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand. Uses one registered log-stage per shift-amount bit. Sits between the ALU operand latch and the writeback mux, with a valid/ready handshake on both sides and a pass-through tag.

Parameters:
WIDTH, 32, operand width; must be a power of two, 8 to 64
TAG_W, 5, width of the sideband tag (destination register index)
SH_W, $clog2(WIDTH), shift-amount width; derived, not overridden

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  unit accepts the operation this cycle
in_data  input  WIDTH  operand
in_amount  input  SH_W  shift distance, 0..WIDTH-1
in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
in_tag  input  TAG_W  sideband carried alongside the result
out_valid  output  1  result available
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  shifted result
out_tag  output  TAG_W  tag of that result
out_zero  output  1  out_data == 0
busy  output  1  OR of all stage valid bits

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Pipeline: SH_W stages. Stage k (k=0..SH_W-1) conditionally shifts by 2^k and registers its output. Latency is exactly SH_W cycles from accept to out_valid when there is no stall (5 cycles for WIDTH=32).
- Per-stage registers: valid, data, remaining amount bits, op, tag, plus the captured sign bit (in_data[WIDTH-1]).
- Fill bits:
  - SLL: zeros in from the LSB side.
  - SRL: zeros in from the MSB side.
  - SRA: the captured sign bit fills from the MSB side. The sign is taken from the original operand, not the intermediate result.
  - ROR: bits leaving the LSB side re-enter at the MSB side.
- Amount 0: the result equals the operand for every op.
- Handshake:
  - advance = !out_valid || out_ready. The whole pipeline moves together only when advance is high.
  - in_ready = advance, combinational. No internal bubble collapsing is required.
  - An operation is accepted when in_valid && in_ready.
  - If in_valid is low while advancing, a bubble (valid=0) enters stage 0.
- Stall: when out_valid && !out_ready, every stage register holds. out_data, out_tag and out_zero stay stable until accepted.
- Throughput: one operation per cycle while out_ready is held high.
- out_zero is computed combinationally from the final stage's data register.
- Reset (any cycle, including mid-operation): all valid bits are cleared. Data, amount, op, tag and sign registers go to 0, so out_data=0, out_tag=0, out_zero=1, out_valid=0 and busy=0. In-flight operations are discarded, not completed. The cycle after reset deasserts, in_ready=1.
- Simultaneous accept at the input and drain at the output in the same cycle is legal and loses nothing.
- X-safety: data registers update only when advance is high; valid registers update on advance or reset.

Decomposition:
- Package shift_pkg:
  - op encodings OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11;
  - a localparam helper for SH_W.
- One natural sub-module, shift_stage:
  - parameters WIDTH and DIST;
  - purely combinational inputs data, enable, op, sign;
  - output shifted data.
- The top level instantiates shift_stage in a generate loop with DIST=2^k and owns all stage registers and handshake logic.

Test Plan:
1. WIDTH=32, SRA 0x80000000 by 31 with out_ready=1 -> after 5 cycles out_data=0xFFFFFFFF, out_valid=1.
2. SRL 0x80000000 by 31 -> 0x00000001. SLL 0x00000001 by 31 -> 0x80000000. ROR 0x00000001 by 1 -> 0x80000000. SRA 0x7FFFFFF0 by 4 -> 0x07FFFFFF. Each result carries its own tag.
3. Back-to-back stream of 8 ops, amounts 0..7 on 0xF0F0F0F0 SRA, out_ready=1 -> 8 consecutive out_valid cycles, in order. Amount 0 returns 0xF0F0F0F0.
4. Backpressure: out_ready=0 for 4 cycles once out_valid rises -> in_ready=0 and out_data held. Release -> all queued results delivered in order, none duplicated or dropped.
5. Reset asserted while 3 ops are in flight -> next cycle out_valid=0, busy=0, out_zero=1, out_data=0. A new op after reset emerges alone with the correct value.
6. WIDTH=8 build: ROR 0x81 by 7 -> 0x03, latency 3 cycles. SLL 0xFF by 0 -> 0xFF, out_zero=0.
